move_scheduler: RTL and testbench

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/move_scheduler_pkg.sv | 44 ++++
 rtl/move_watchdog.sv | 43 ++++
 rtl/move_scheduler.sv | 162 ++++++++++++++++
 tb/tb_move_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/move_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// move_scheduler_pkg
// Shared game definitions for the move scheduler block:
//   - scene encodings (start / play / win / lose)
//   - actor index constants (pac, blinky, clyde) used as grant/req/done bits
//   - FSM state encoding of the scheduler
//   - nextEligible(): picks the next actor state in fixed pac->blinky->clyde
//     order, or CHECK when nobody further down the order may move
// ---------------------------------------------------------------------------
package move_scheduler_pkg;

    localparam logic [1:0] SCENE_START = 2'b00;
    localparam logic [1:0] SCENE_PLAY  = 2'b01;
    localparam logic [1:0] SCENE_WIN   = 2'b10;
    localparam logic [1:0] SCENE_LOSE  = 2'b11;

    localparam int ACT_PAC    = 0;
    localparam int ACT_BLINKY = 1;
    localparam int ACT_CLYDE  = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PAC    = 3'd1;
    localparam logic [2:0] ST_BLINKY = 3'd2;
    localparam logic [2:0] ST_CLYDE  = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;

    // Only actors strictly after 'cur' in the fixed order are considered;
    // from IDLE every actor is a candidate. Ghosts also need their phase slot.
    function automatic logic [2:0] nextEligible(input logic [2:0] cur,
                                                input logic [2:0] req,
                                                input logic       ghostOk);
        logic [2:0] ns;
        ns = ST_CHECK;
        if (cur == ST_IDLE && req[ACT_PAC])
            ns = ST_PAC;
        else if ((cur == ST_IDLE || cur == ST_PAC) && req[ACT_BLINKY] && ghostOk)
            ns = ST_BLINKY;
        else if ((cur == ST_IDLE || cur == ST_PAC || cur == ST_BLINKY) &&
                 req[ACT_CLYDE] && ghostOk)
            ns = ST_CLYDE;
        return ns;
    endfunction

endpackage

// File: rtl/move_watchdog.sv
// ---------------------------------------------------------------------------
// move_watchdog
// Per-grant cycle counter with a compare against TIMEOUT. Only instantiated
// by move_scheduler when MOVE_SCHED_WATCHDOG_EN is defined.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   active_i     scheduler is in an actor state this cycle
//   clear_i      scheduler state changes on the coming edge
//   expired_o    this is the TIMEOUT-th cycle of the current grant
// ---------------------------------------------------------------------------
module move_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic clear_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    // Counter reads 0 on the first cycle of every grant, so the compare with
    // TIMEOUT-1 fires on the TIMEOUT-th granted cycle. It saturates rather
    // than wrapping so a stuck state can never re-arm a spurious expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !active_i)
            cnt_d = 8'd0;
        else if (cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = active_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/move_scheduler.sv
// ---------------------------------------------------------------------------
// move_scheduler
// Sequences one game step: on an accepted tick it grants pac, blinky and
// clyde in turn (skipping non-eligible actors), then strobes check_stb for
// one cycle so collision/scene logic can evaluate the step.
// Optional feature: define MOVE_SCHED_WATCHDOG_EN to add a per-grant
// watchdog that forces progress after TIMEOUT cycles and records which
// actor stalled in timeout_flags.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   tick            one-cycle game-step pulse
//   scene           current scene, 2'b01 = play
//   req[2:0]        move request per actor (0 pac, 1 blinky, 2 clyde)
//   done[2:0]       move-complete pulse per actor
//   grant[2:0]      one-hot registered move permission
//   check_stb       one-cycle post-step evaluation strobe
//   busy            scheduler not in IDLE
//   overrun_cnt     saturating count of dropped ticks
//   timeout_flags   sticky per-actor watchdog flags (0 without watchdog)
// ---------------------------------------------------------------------------
module move_scheduler
    import move_scheduler_pkg::*;
#(
    parameter int GHOST_DIV = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] scene,
    input  logic [2:0] req,
    input  logic [2:0] done,
    output logic [2:0] grant,
    output logic       check_stb,
    output logic       busy,
    output logic [7:0] overrun_cnt,
    output logic [2:0] timeout_flags
);

    localparam logic [3:0] PHASE_LAST = 4'(GHOST_DIV - 1);

    if (GHOST_DIV < 1 || GHOST_DIV > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_badParams
        $error("move_scheduler: GHOST_DIV or TIMEOUT out of range");
    end

    logic [2:0] state_q, state_d;
    logic [3:0] ghostPhase_q, ghostPhase_d;
    logic       ghostOk_q, ghostOk_d;
    logic [7:0] overrunCnt_q, overrunCnt_d;
    logic [2:0] grant_q, grant_d;
    logic       checkStb_q, checkStb_d;

    logic scenePlay, inActor, grantedDone, advance;

    assign scenePlay   = (scene == SCENE_PLAY);
    assign inActor     = (state_q == ST_PAC) || (state_q == ST_BLINKY) || (state_q == ST_CLYDE);
    // grant_q is one-hot for the current actor, so it masks out done pulses
    // from actors that are not currently allowed to move.
    assign grantedDone = |(done & grant_q);

`ifdef MOVE_SCHED_WATCHDOG_EN
    logic       expired;
    logic [2:0] flags_q, flags_d;

    move_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .active_i  (inActor),
        .clear_i   (state_d != state_q),
        .expired_o (expired)
    );

    assign advance = inActor && (grantedDone || expired);

    // A stall is only blamed on the actor when the limit is hit without a
    // real done in the same cycle.
    always_comb begin
        flags_d = flags_q;
        if (inActor && expired && !grantedDone)
            flags_d = flags_q | grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst)
            flags_q <= 3'b000;
        else
            flags_q <= flags_d;
    end

    assign timeout_flags = flags_q;
`else
    assign advance       = inActor && grantedDone;
    assign timeout_flags = 3'b000;
`endif

    // Main sequencing. The ghost phase slot is sampled once at tick
    // acceptance (pre-increment value) and held for the whole step, so both
    // ghosts see the same decision. Leaving the play scene overrides every
    // transition, and ticks seen while busy in play are counted as dropped.
    always_comb begin
        state_d      = state_q;
        ghostPhase_d = ghostPhase_q;
        ghostOk_d    = ghostOk_q;
        overrunCnt_d = overrunCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (tick && scenePlay) begin
                    ghostOk_d    = (ghostPhase_q == 4'd0);
                    ghostPhase_d = (ghostPhase_q >= PHASE_LAST) ? 4'd0 : ghostPhase_q + 4'd1;
                    state_d      = nextEligible(ST_IDLE, req, ghostPhase_q == 4'd0);
                end
            end
            ST_PAC, ST_BLINKY, ST_CLYDE: begin
                if (advance)
                    state_d = nextEligible(state_q, req, ghostOk_q);
            end
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && !scenePlay)
            state_d = ST_IDLE;
        if (state_q != ST_IDLE && scenePlay && tick && overrunCnt_q != 8'hFF)
            overrunCnt_d = overrunCnt_q + 8'd1;
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state register.
    always_comb begin
        grant_d    = 3'b000;
        checkStb_d = (state_d == ST_CHECK);
        case (state_d)
            ST_PAC:    grant_d[ACT_PAC]    = 1'b1;
            ST_BLINKY: grant_d[ACT_BLINKY] = 1'b1;
            ST_CLYDE:  grant_d[ACT_CLYDE]  = 1'b1;
            default:   grant_d             = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ghostPhase_q <= 4'd0;
            ghostOk_q    <= 1'b0;
            overrunCnt_q <= 8'd0;
            grant_q      <= 3'b000;
            checkStb_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ghostPhase_q <= ghostPhase_d;
            ghostOk_q    <= ghostOk_d;
            overrunCnt_q <= overrunCnt_d;
            grant_q      <= grant_d;
            checkStb_q   <= checkStb_d;
        end
    end

    assign grant       = grant_q;
    assign check_stb   = checkStb_q;
    assign busy        = (state_q != ST_IDLE);
    assign overrun_cnt = overrunCnt_q;

endmodule

// File: tb/tb_move_scheduler.sv
// ---------------------------------------------------------------------------
// tb_move_scheduler
// Directed and randomized checks of move_scheduler (GHOST_DIV=2, TIMEOUT=15)
// against a transaction-level model: each accepted tick yields a list of
// actors to serve, derived from req and the count of accepted ticks.
// ---------------------------------------------------------------------------
module tb_move_scheduler;
    import move_scheduler_pkg::*;

    localparam int GD = 2;
    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] scene;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] grant;
    logic       check_stb;
    logic       busy;
    logic [7:0] overrun_cnt;
    logic [2:0] timeout_flags;

    int         tests = 0;
    int         fails = 0;
    int         accepted;
    int         expOverrun;
    logic [2:0] expFlags;

    always #5 clk = ~clk;

    move_scheduler #(.GHOST_DIV(GD), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .scene         (scene),
        .req           (req),
        .done          (done),
        .grant         (grant),
        .check_stb     (check_stb),
        .busy          (busy),
        .overrun_cnt   (overrun_cnt),
        .timeout_flags (timeout_flags)
    );

    // Hard time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic [1:0] s, input logic [2:0] r, input logic [2:0] d);
        tick  = t;
        scene = s;
        req   = r;
        done  = d;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, SCENE_PLAY, 3'b000, 3'b000);
        cyc();
        rst        = 1'b0;
        accepted   = 0;
        expOverrun = 0;
        expFlags   = 3'b000;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".grant"}, grant, 3'b000);
        checkOutput({tag, ".check_stb"}, check_stb, 1'b0);
        checkOutput({tag, ".busy"}, busy, 1'b0);
        checkOutput({tag, ".overrun"}, overrun_cnt, expOverrun);
        checkOutput({tag, ".flags"}, timeout_flags, expFlags);
    endtask

    // One full game step. fixedDelay>0 forces done that many cycles after each
    // grant, otherwise 1..5. tickPct is the chance of a stray tick per busy
    // cycle; noise adds done pulses on non-granted bits.
    task automatic runSeq(input logic [2:0] r, input int fixedDelay, input int tickPct, input bit noise);
        int         q[$];
        bit         ghostTurn;
        int         d;
        logic       t;
        logic [2:0] own, nz;
        ghostTurn = ((accepted % GD) == 0);
        accepted++;
        if (r[0]) q.push_back(ACT_PAC);
        if (r[1] && ghostTurn) q.push_back(ACT_BLINKY);
        if (r[2] && ghostTurn) q.push_back(ACT_CLYDE);
        applyStimulus(1'b1, SCENE_PLAY, r, 3'b000);
        cyc();
        foreach (q[i]) begin
            own = 3'(1 << q[i]);
            d   = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(1, 5));
            for (int k = 0; k < d; k++) begin
                checkOutput("seq.grant", grant, own);
                checkOutput("seq.busy", busy, 1'b1);
                checkOutput("seq.check_stb", check_stb, 1'b0);
                t = ($urandom_range(0, 99) < tickPct);
                if (t && expOverrun < 255) expOverrun++;
                nz = noise ? (3'($urandom) & ~own) : 3'b000;
                applyStimulus(t, SCENE_PLAY, r, (k == d - 1) ? (own | nz) : nz);
                cyc();
            end
        end
        checkOutput("chk.grant", grant, 3'b000);
        checkOutput("chk.check_stb", check_stb, 1'b1);
        checkOutput("chk.busy", busy, 1'b1);
        t = ($urandom_range(0, 99) < tickPct);
        if (t && expOverrun < 255) expOverrun++;
        applyStimulus(t, SCENE_PLAY, r, 3'b000);
        cyc();
        checkIdle("end");
        applyStimulus(1'b0, SCENE_PLAY, r, 3'b000);
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, SCENE_PLAY, 3'b000, 3'b000);

        doReset();
        checkIdle("reset");

        // All three actors, done two cycles after each grant.
        runSeq(3'b111, 2, 0, 1'b0);

        // Ghost divider: ghosts only on accepted ticks 1 and 3.
        doReset();
        for (int i = 0; i < 4; i++) runSeq(3'b111, 0, 0, 1'b0);

        // Scene leaves play while blinky holds the grant.
        doReset();
        applyStimulus(1'b1, SCENE_PLAY, 3'b111, 3'b000);
        cyc();
        checkOutput("abort.pac", grant, 3'b001);
        applyStimulus(1'b0, SCENE_PLAY, 3'b111, 3'b001);
        cyc();
        checkOutput("abort.blinky", grant, 3'b010);
        applyStimulus(1'b1, SCENE_LOSE, 3'b111, 3'b000);
        cyc();
        checkIdle("abort");
        applyStimulus(1'b1, SCENE_LOSE, 3'b111, 3'b000);
        cyc();
        checkIdle("ignored_tick");
        applyStimulus(1'b0, SCENE_PLAY, 3'b000, 3'b000);

        // Reset while clyde is granted, with tick and done on the same edge.
        doReset();
        applyStimulus(1'b1, SCENE_PLAY, 3'b100, 3'b000);
        cyc();
        checkOutput("rst.clyde", grant, 3'b100);
        applyStimulus(1'b1, SCENE_PLAY, 3'b100, 3'b000);
        cyc();
        checkOutput("rst.overrun", overrun_cnt, 8'd1);
        rst = 1'b1;
        applyStimulus(1'b1, SCENE_PLAY, 3'b100, 3'b100);
        cyc();
        rst        = 1'b0;
        accepted   = 0;
        expOverrun = 0;
        expFlags   = 3'b000;
        checkIdle("rst_mid");
        applyStimulus(1'b0, SCENE_PLAY, 3'b000, 3'b000);

        // Clyde never finishes its move.
        doReset();
        applyStimulus(1'b1, SCENE_PLAY, 3'b100, 3'b000);
        cyc();
        applyStimulus(1'b0, SCENE_PLAY, 3'b100, 3'b000);
`ifdef MOVE_SCHED_WATCHDOG_EN
        for (int k = 0; k < TO; k++) begin
            checkOutput("wd.grant", grant, 3'b100);
            cyc();
        end
        expFlags = 3'b100;
        checkOutput("wd.drop", grant, 3'b000);
        checkOutput("wd.check_stb", check_stb, 1'b1);
        checkOutput("wd.flags", timeout_flags, expFlags);
        cyc();
        checkIdle("wd.end");
`else
        for (int k = 0; k < 1000; k++) begin
            checkOutput("hold.grant", grant, 3'b100);
            checkOutput("hold.flags", timeout_flags, 3'b000);
            cyc();
        end
        applyStimulus(1'b0, SCENE_START, 3'b100, 3'b000);
        cyc();
        checkIdle("hold.end");
`endif
        applyStimulus(1'b0, SCENE_PLAY, 3'b000, 3'b000);

        // Randomized steps with stray ticks and done noise.
        doReset();
        for (int i = 0; i < 30; i++) runSeq(3'($urandom), 0, 30, 1'b1);

        // Overrun counter saturation.
        doReset();
        for (int i = 0; i < 40; i++) runSeq(3'b111, 5, 100, 1'b0);
        checkOutput("overrun.sat", overrun_cnt, 8'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
